// File: rtl/joystick_dir_queue_if.sv
// Pin-side joystick inputs, game tick and per-player direction outputs.
// The slave side is the decoder; the master side drives the buttons and tick.
interface joystick_dir_queue_if #(
  parameter int NUM_PLAYERS = 2
);
  logic [4*NUM_PLAYERS-1:0] btn_raw;
  logic                     tick;
  logic [2*NUM_PLAYERS-1:0] dir_out;
  logic [NUM_PLAYERS-1:0]   dir_changed;
  logic [NUM_PLAYERS-1:0]   queue_full;
  logic [NUM_PLAYERS-1:0]   turn_dropped;

  modport master (
    output btn_raw, tick,
    input  dir_out, dir_changed, queue_full, turn_dropped
  );

  modport slave (
    input  btn_raw, tick,
    output dir_out, dir_changed, queue_full, turn_dropped
  );
endinterface

// File: rtl/joystick_dir_queue.sv
// Per-player joystick sync/debounce, turn validation and a small turn queue drained one entry per tick.
// Raw edge reaches the queue after 2 + DEBOUNCE_CYCLES + 1 cycles; a full queue drops new turns (turn_dropped).
module joystick_dir_queue #(
  parameter int         NUM_PLAYERS     = 2,
  parameter int         DEBOUNCE_CYCLES = 50000,
  parameter int         QUEUE_DEPTH     = 2,
  parameter logic [3:0] INVERT_MASK     = 4'b1010,
  parameter logic [1:0] INIT_DIR        = 2'b00
) (
  input  logic clk,
  input  logic rst,
  joystick_dir_queue_if.slave js
);
  localparam int DBW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int CNTW = $clog2(QUEUE_DEPTH + 1);
  localparam int PTRW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam logic [DBW-1:0]  DB_LAST  = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PTRW-1:0] PTR_LAST = PTRW'(QUEUE_DEPTH - 1);
  localparam logic [CNTW-1:0] CNT_MAX  = CNTW'(QUEUE_DEPTH);

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    logic [3:0]      sync1_q, sync2_q, level;
    logic [3:0]      deb_q, deb_d;
    logic [DBW-1:0]  dbc_q [4];
    logic [DBW-1:0]  dbc_d [4];
    logic            press_vld_q, press_vld_d;
    logic [1:0]      press_dir_q, press_dir_d;
    logic [1:0]      mem_q [QUEUE_DEPTH];
    logic [PTRW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, tail_ptr;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [1:0]      dir_q, dir_d, ref_dir;
    logic            chg_q, drop_q, full_q;
    logic            pop, accept, push, drop;

    assign level = sync2_q ^ INVERT_MASK;

    always_comb begin
      deb_d = deb_q;
      for (int b = 0; b < 4; b++) begin
        dbc_d[b] = '0;
        if (level[b] != deb_q[b]) begin
          if (dbc_q[b] == DB_LAST) deb_d[b] = level[b];
          else                     dbc_d[b] = dbc_q[b] + 1'b1;
        end
      end
    end

    // A press only counts if the new level is a single held button.
    always_comb begin
      press_dir_d = '0;
      for (int b = 0; b < 4; b++) begin
        if (deb_d[b]) press_dir_d = 2'(b);
      end
      press_vld_d = (|(deb_d & ~deb_q)) && ($countones(deb_d) == 1);
    end

    always_comb begin
      tail_ptr = (wr_ptr_q == '0) ? PTR_LAST : wr_ptr_q - 1'b1;
      ref_dir  = (cnt_q != '0) ? mem_q[tail_ptr] : dir_q;
      pop      = js.tick && (cnt_q != '0);
      accept   = press_vld_q && (press_dir_q != ref_dir) &&
                 (press_dir_q != (ref_dir ^ 2'b10));
      push     = accept && ((cnt_q != CNT_MAX) || pop);
      drop     = accept && !push;
      rd_ptr_d = pop  ? ((rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
      wr_ptr_d = push ? ((wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
      cnt_d    = cnt_q;
      if (push && !pop)      cnt_d = cnt_q + 1'b1;
      else if (pop && !push) cnt_d = cnt_q - 1'b1;
      dir_d    = pop ? mem_q[rd_ptr_q] : dir_q;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        sync1_q     <= INVERT_MASK;
        sync2_q     <= INVERT_MASK;
        deb_q       <= '0;
        for (int b = 0; b < 4; b++) dbc_q[b] <= '0;
        press_vld_q <= 1'b0;
        press_dir_q <= '0;
        for (int i = 0; i < QUEUE_DEPTH; i++) mem_q[i] <= '0;
        rd_ptr_q    <= '0;
        wr_ptr_q    <= '0;
        cnt_q       <= '0;
        dir_q       <= INIT_DIR;
        chg_q       <= 1'b0;
        drop_q      <= 1'b0;
        full_q      <= 1'b0;
      end else begin
        sync1_q     <= js.btn_raw[4*p +: 4];
        sync2_q     <= sync1_q;
        deb_q       <= deb_d;
        for (int b = 0; b < 4; b++) dbc_q[b] <= dbc_d[b];
        press_vld_q <= press_vld_d;
        press_dir_q <= press_dir_d;
        if (push) mem_q[wr_ptr_q] <= press_dir_q;
        rd_ptr_q    <= rd_ptr_d;
        wr_ptr_q    <= wr_ptr_d;
        cnt_q       <= cnt_d;
        dir_q       <= dir_d;
        chg_q       <= pop;
        drop_q      <= drop;
        full_q      <= (cnt_d == CNT_MAX);
      end
    end

    assign js.dir_out[2*p +: 2] = dir_q;
    assign js.dir_changed[p]    = chg_q;
    assign js.queue_full[p]     = full_q;
    assign js.turn_dropped[p]   = drop_q;
  end
endmodule

// File: tb/tb_joystick_dir_queue.sv
// Directed scenarios then random button/tick/reset traffic, every cycle compared against a queue-based model.
module tb_joystick_dir_queue;
  localparam int         NP    = 2;
  localparam int         DB    = 4;
  localparam int         QD    = 2;
  localparam logic [3:0] INV   = 4'b1010;
  localparam logic [1:0] INITD = 2'b00;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  joystick_dir_queue_if #(.NUM_PLAYERS(NP)) js ();

  joystick_dir_queue #(
    .NUM_PLAYERS(NP), .DEBOUNCE_CYCLES(DB), .QUEUE_DEPTH(QD),
    .INVERT_MASK(INV), .INIT_DIR(INITD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .js (js)
  );

  int errors = 0;
  int checks = 0;

  // Logical (pressed = 1) button state per player; the pins see it through INV.
  logic [3:0] lvl [NP];

  // Reference model: delayed samples, run lengths and a plain array queue.
  logic [3:0] m_s1 [NP];
  logic [3:0] m_s2 [NP];
  logic [3:0] m_deb [NP];
  int         m_run [NP][4];
  bit         m_pv [NP];
  int         m_pd [NP];
  int         m_q [NP][QD];
  int         m_cnt [NP];
  int         m_dir [NP];
  bit         m_chg [NP];
  bit         m_drop [NP];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      m_s1[p] = '0; m_s2[p] = '0; m_deb[p] = '0;
      for (int b = 0; b < 4; b++) m_run[p][b] = 0;
      m_pv[p] = 0; m_pd[p] = 0; m_cnt[p] = 0;
      m_dir[p] = int'(INITD); m_chg[p] = 0; m_drop[p] = 0;
    end
  endtask

  task automatic model_step();
    if (rst) begin
      model_reset();
      return;
    end
    for (int p = 0; p < NP; p++) begin
      int         rf;
      bit         pop, acc;
      logic [3:0] nd, rise;
      rf  = (m_cnt[p] > 0) ? m_q[p][m_cnt[p]-1] : m_dir[p];
      pop = js.tick && (m_cnt[p] > 0);
      acc = m_pv[p] && (m_pd[p] != rf) && (m_pd[p] != (rf ^ 2));
      m_chg[p]  = pop;
      m_drop[p] = 0;
      if (pop) begin
        m_dir[p] = m_q[p][0];
        for (int i = 0; i < QD - 1; i++) m_q[p][i] = m_q[p][i+1];
        m_cnt[p]--;
      end
      if (acc) begin
        if (m_cnt[p] < QD) begin
          m_q[p][m_cnt[p]] = m_pd[p];
          m_cnt[p]++;
        end else m_drop[p] = 1;
      end
      // A level is accepted after DB consecutive differing cycles.
      nd = m_deb[p];
      for (int b = 0; b < 4; b++) begin
        if (m_s2[p][b] != m_deb[p][b]) begin
          m_run[p][b]++;
          if (m_run[p][b] >= DB) begin
            nd[b] = m_s2[p][b];
            m_run[p][b] = 0;
          end
        end else m_run[p][b] = 0;
      end
      rise = nd & ~m_deb[p];
      m_pv[p] = (rise != 0) && ($countones(nd) == 1);
      m_pd[p] = 0;
      for (int b = 0; b < 4; b++) if (nd[b]) m_pd[p] = b;
      m_deb[p] = nd;
      m_s2[p]  = m_s1[p];
      m_s1[p]  = lvl[p];
    end
  endtask

  task automatic compare_all();
    logic [2*NP-1:0] ed;
    logic [NP-1:0]   ec, ef, et;
    for (int p = 0; p < NP; p++) begin
      ed[2*p +: 2] = 2'(m_dir[p]);
      ec[p] = m_chg[p];
      ef[p] = (m_cnt[p] == QD);
      et[p] = m_drop[p];
    end
    chk("dir_out", 32'(js.dir_out), 32'(ed));
    chk("dir_changed", 32'(js.dir_changed), 32'(ec));
    chk("queue_full", 32'(js.queue_full), 32'(ef));
    chk("turn_dropped", 32'(js.turn_dropped), 32'(et));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic set_lvl(int p, logic [3:0] v);
    lvl[p] = v;
    js.btn_raw[4*p +: 4] = v ^ INV;
  endtask

  task automatic hold(int n);
    repeat (n) cyc();
  endtask

  task automatic press(int p, logic [3:0] v);
    set_lvl(p, v);
    hold(10);
    set_lvl(p, 4'b0000);
    hold(9);
  endtask

  task automatic tick1();
    js.tick = 1'b1;
    cyc();
    js.tick = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    int ndrop;
    rst = 1'b1;
    js.tick = 1'b0;
    set_lvl(0, 4'b0000);
    set_lvl(1, 4'b0000);
    model_reset();
    cyc();
    cyc();
    chk("rst_dir", 32'(js.dir_out), 32'h0);
    chk("rst_full", 32'(js.queue_full), 32'h0);
    chk("rst_pulses", 32'({js.dir_changed, js.turn_dropped}), 32'h0);
    rst = 1'b0;
    hold(2);

    // RIGHT on P0 then tick
    press(0, 4'b0010);
    tick1();
    chk("t1_dir", 32'(js.dir_out), 32'h1);
    chk("t1_chg", 32'(js.dir_changed), 32'h1);
    cyc();
    chk("t1_chg_once", 32'(js.dir_changed), 32'h0);

    // 3-cycle glitch must not register
    set_lvl(0, 4'b0010);
    hold(3);
    set_lvl(0, 4'b0000);
    hold(10);
    tick1();
    chk("t2_chg", 32'(js.dir_changed), 32'h0);
    chk("t2_dir", 32'(js.dir_out), 32'h1);

    // Reversal and duplicate from UP
    do_reset();
    press(0, 4'b0100);
    press(0, 4'b0001);
    tick1();
    chk("t3_dir", 32'(js.dir_out), 32'h0);
    chk("t3_chg", 32'(js.dir_changed), 32'h0);

    // RIGHT then DOWN: DOWN validated against tail RIGHT
    press(0, 4'b0010);
    press(0, 4'b0100);
    chk("t4_full", 32'(js.queue_full), 32'h1);
    js.tick = 1'b1;
    cyc();
    chk("t4_dir1", 32'(js.dir_out), 32'h1);
    chk("t4_chg1", 32'(js.dir_changed), 32'h1);
    cyc();
    chk("t4_dir2", 32'(js.dir_out), 32'h2);
    chk("t4_chg2", 32'(js.dir_changed), 32'h1);
    js.tick = 1'b0;
    cyc();
    chk("t4_empty", 32'(js.queue_full), 32'h0);

    // Overflow, then LEFT landing in a tick cycle
    do_reset();
    press(0, 4'b0010);
    press(0, 4'b0100);
    ndrop = 0;
    set_lvl(0, 4'b1000);
    repeat (10) begin cyc(); if (js.turn_dropped[0]) ndrop++; end
    set_lvl(0, 4'b0000);
    repeat (9) begin cyc(); if (js.turn_dropped[0]) ndrop++; end
    chk("t5_drops", 32'(ndrop), 32'h1);
    chk("t5_full", 32'(js.queue_full), 32'h1);
    chk("t5_dir", 32'(js.dir_out), 32'h0);
    set_lvl(0, 4'b1000);
    hold(6);
    js.tick = 1'b1;
    cyc();
    js.tick = 1'b0;
    chk("t5_tick_dir", 32'(js.dir_out), 32'h1);
    chk("t5_tick_drop", 32'(js.turn_dropped), 32'h0);
    chk("t5_tick_full", 32'(js.queue_full), 32'h1);
    hold(3);
    set_lvl(0, 4'b0000);
    hold(8);
    tick1();
    chk("t5_dir_down", 32'(js.dir_out), 32'h2);
    tick1();
    chk("t5_dir_left", 32'(js.dir_out), 32'h3);
    tick1();
    chk("t5_no_more", 32'(js.dir_changed), 32'h0);

    // Simultaneous UP+RIGHT ignored; reset discards queued turns
    do_reset();
    press(0, 4'b0011);
    tick1();
    chk("t6_two_chg", 32'(js.dir_changed), 32'h0);
    chk("t6_two_dir", 32'(js.dir_out), 32'h0);
    press(0, 4'b0010);
    press(0, 4'b0100);
    chk("t6_full", 32'(js.queue_full), 32'h1);
    do_reset();
    chk("t6_rst_dir", 32'(js.dir_out), 32'h0);
    chk("t6_rst_full", 32'(js.queue_full), 32'h0);
    chk("t6_rst_pulse", 32'({js.dir_changed, js.turn_dropped}), 32'h0);
    tick1();
    chk("t6_tick_chg", 32'(js.dir_changed), 32'h0);

    // P1 independent of P0
    press(1, 4'b1000);
    tick1();
    chk("p1_dir", 32'(js.dir_out), 32'hC);
    chk("p1_chg", 32'(js.dir_changed), 32'h2);

    // Random traffic
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        int p, r;
        p = int'($urandom_range(0, NP - 1));
        r = int'($urandom_range(0, 9));
        if (r <= 5)      set_lvl(p, 4'(1 << $urandom_range(0, 3)));
        else if (r <= 8) set_lvl(p, 4'b0000);
        else             set_lvl(p, 4'($urandom_range(0, 15)));
      end
      js.tick = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 599) == 0);
      cyc();
    end
    rst = 1'b0;
    js.tick = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
